// File: rtl/mxu_host_if.sv
// Host front end for the matrix multiply unit: streams in A/B operand bytes,
// launches the unit, captures its accumulators and streams the results back out.
module mxu_host_if #(
  parameter int SIZE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [7:0]                 s_data,
  input  logic                       cycles_cfg,
  output logic [SIZE*SIZE*8-1:0]     mxu_data_a,
  output logic [SIZE*SIZE*8-1:0]     mxu_data_b,
  output logic                       mxu_start,
  output logic                       mxu_cycles,
  input  logic                       mxu_done,
  input  logic [SIZE*SIZE*32-1:0]    mxu_d_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [31:0]                m_data,
  output logic                       m_last,
  output logic                       busy
);

  localparam int unsigned N  = SIZE * SIZE;
  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [N*8-1:0]      r_a;
  logic [N*8-1:0]      r_b;
  logic                r_cycles;
  logic [31:0]         r_res [N];

  logic                w_s_fire;
  logic                w_m_fire;
  logic                w_idx_last;

  assign w_s_fire   = s_valid & s_ready;
  assign w_m_fire   = m_valid & m_ready;
  assign w_idx_last = (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      LOAD_A: if (w_s_fire && w_idx_last) w_state_nxt = LOAD_B;
      LOAD_B: if (w_s_fire && w_idx_last) w_state_nxt = START;
      START:  w_state_nxt = WAIT;
      WAIT:   if (mxu_done) w_state_nxt = DRAIN;
      DRAIN:  if (w_m_fire && w_idx_last) w_state_nxt = LOAD_A;
      default: w_state_nxt = LOAD_A;
    endcase
  end

  // One shared index walks operand bytes while loading and result words while draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cycles <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        r_res[k] <= '0;
      end
    end else begin
      unique case (r_state)
        LOAD_A: begin
          if (w_s_fire) begin
            r_a[{r_idx, 3'b000} +: 8] <= s_data;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
          end
        end
        LOAD_B: begin
          if (w_s_fire) begin
            r_b[{r_idx, 3'b000} +: 8] <= s_data;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            if (w_idx_last) begin
              r_cycles <= cycles_cfg;
            end
          end
        end
        WAIT: begin
          if (mxu_done) begin
            for (int unsigned k = 0; k < N; k++) begin
              r_res[k] <= mxu_d_in[k*32 +: 32];
            end
          end
        end
        DRAIN: begin
          if (w_m_fire) begin
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_data = '0;
    if (r_state == DRAIN) begin
      m_data = r_res[r_idx];
    end
  end

  assign s_ready    = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign m_valid    = (r_state == DRAIN);
  assign m_last     = (r_state == DRAIN) && w_idx_last;
  assign mxu_start  = (r_state == START);
  assign busy       = (r_state == START) || (r_state == WAIT) || (r_state == DRAIN);
  assign mxu_data_a = r_a;
  assign mxu_data_b = r_b;
  assign mxu_cycles = r_cycles;

endmodule

// File: tb/tb_mxu_host_if.sv
// Directed bench for mxu_host_if: a cycle table for the first job, then
// hand-written jobs covering gaps, backpressure, reset abort and reload.
module tb_mxu_host_if;

  localparam int SIZE = 4;
  localparam int N    = SIZE * SIZE;

  logic           clk;
  logic           reset;
  logic           s_valid;
  logic           s_ready;
  logic [7:0]     s_data;
  logic           cycles_cfg;
  logic [N*8-1:0] mxu_data_a;
  logic [N*8-1:0] mxu_data_b;
  logic           mxu_start;
  logic           mxu_cycles;
  logic           mxu_done;
  logic [N*32-1:0] mxu_d_in;
  logic           m_valid;
  logic           m_ready;
  logic [31:0]    m_data;
  logic           m_last;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  mxu_host_if #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cycles_cfg (cycles_cfg),
    .mxu_data_a (mxu_data_a),
    .mxu_data_b (mxu_data_b),
    .mxu_start  (mxu_start),
    .mxu_cycles (mxu_cycles),
    .mxu_done   (mxu_done),
    .mxu_d_in   (mxu_d_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        done;
    logic        mr;
    logic        e_sready;
    logic        e_start;
    logic        e_busy;
    logic        e_mvalid;
    logic [31:0] e_mdata;
    logic        e_mlast;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack_inc(input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic set_din(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < N; k++) mxu_d_in[k*32 +: 32] = base + step * 32'(k);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " s_ready"},    128'(s_ready),    128'd1);
    chk({tag, " m_valid"},    128'(m_valid),    128'd0);
    chk({tag, " m_last"},     128'(m_last),     128'd0);
    chk({tag, " m_data"},     128'(m_data),     128'd0);
    chk({tag, " mxu_start"},  128'(mxu_start),  128'd0);
    chk({tag, " mxu_cycles"}, 128'(mxu_cycles), 128'd0);
    chk({tag, " busy"},       128'(busy),       128'd0);
    chk({tag, " data_a"},     mxu_data_a,       128'd0);
    chk({tag, " data_b"},     mxu_data_b,       128'd0);
  endtask

  // Loads 2N bytes, s_valid high every gap-th cycle; returns in WAIT cycle 0.
  task automatic load(input logic [127:0] a, input logic [127:0] b, input logic cfg,
                      input int gap, input logic spur);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    cycles_cfg = cfg;
    while (sent < 2*N && cyc < 500) begin
      s_valid  = ((cyc % gap) == 0);
      s_data   = (sent < N) ? a[sent*8 +: 8] : b[(sent-N)*8 +: 8];
      mxu_done = spur && (sent < N) && ((cyc % 2) == 1);
      chk("load s_ready", 128'(s_ready), 128'd1);
      chk("load busy",    128'(busy),    128'd0);
      tick();
      if (s_valid) sent++;
      cyc++;
    end
    s_valid  = 1'b0;
    mxu_done = 1'b0;
    if (cyc >= 500) chk("load bound", 128'(sent), 128'(2*N));
    chk("start pulse",  128'(mxu_start), 128'd1);
    chk("start busy",   128'(busy),      128'd1);
    chk("start sready", 128'(s_ready),   128'd0);
    chk("operand A",    mxu_data_a,      a);
    chk("operand B",    mxu_data_b,      b);
    chk("mxu_cycles",   128'(mxu_cycles), 128'(cfg));
    tick();
    chk("wait start low", 128'(mxu_start), 128'd0);
    chk("wait busy",      128'(busy),      128'd1);
    chk("wait m_valid",   128'(m_valid),   128'd0);
  endtask

  task automatic run_wait(input int n, input logic [31:0] base, input logic [31:0] step);
    set_din(base, step);
    for (int j = 0; j < n; j++) begin
      mxu_done = 1'b0;
      chk("wait hold", 128'(m_valid), 128'd0);
      tick();
    end
    mxu_done = 1'b1;
    tick();
    mxu_done = 1'b0;
    set_din(32'hDEAD_0000, 32'd0);
  endtask

  task automatic drain(input logic [31:0] base, input logic [31:0] step, input logic toggle);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      m_ready = !toggle || ((cyc % 2) == 0);
      chk("drain m_valid", 128'(m_valid), 128'd1);
      chk($sformatf("drain word%0d", k), 128'(m_data), 128'(base + step * 32'(k)));
      chk("drain m_last", 128'(m_last), 128'(k == N-1));
      tick();
      if (m_ready) k++;
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain handshakes", 128'(k), 128'(N));
    chk("drain cycles", 128'(cyc), toggle ? 128'(2*N-1) : 128'(N));
    chk("post drain s_ready", 128'(s_ready), 128'd1);
    chk("post drain m_valid", 128'(m_valid), 128'd0);
    chk("post drain busy",    128'(busy),    128'd0);
  endtask

  initial begin
    vec_t v;
    reset      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    cycles_cfg = 1'b0;
    mxu_done   = 1'b0;
    m_ready    = 1'b0;
    set_din(32'd0, 32'h100);

    // Job 1 cycle table: 2N load cycles, START (with spurious done), 6 WAIT, N DRAIN, LOAD_A.
    for (int i = 0; i < 2*N; i++) begin
      v = '{1'b1, 8'(i+1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
      tbl.push_back(v);
    end
    v = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    tbl.push_back(v);
    for (int w = 0; w < 6; w++) begin
      v = '{1'b0, 8'h00, (w == 5), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
      tbl.push_back(v);
    end
    for (int k = 0; k < N; k++) begin
      v = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'(k) * 32'h100, (k == N-1)};
      tbl.push_back(v);
    end
    v = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl.push_back(v);

    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b1;
    tick();

    cycles_cfg = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      s_valid  = tbl[i].sv;
      s_data   = tbl[i].sd;
      mxu_done = tbl[i].done;
      m_ready  = tbl[i].mr;
      chk($sformatf("row%0d s_ready", i), 128'(s_ready),   128'(tbl[i].e_sready));
      chk($sformatf("row%0d start", i),   128'(mxu_start), 128'(tbl[i].e_start));
      chk($sformatf("row%0d busy", i),    128'(busy),      128'(tbl[i].e_busy));
      chk($sformatf("row%0d m_valid", i), 128'(m_valid),   128'(tbl[i].e_mvalid));
      chk($sformatf("row%0d m_data", i),  128'(m_data),    128'(tbl[i].e_mdata));
      chk($sformatf("row%0d m_last", i),  128'(m_last),    128'(tbl[i].e_mlast));
      tick();
    end
    s_valid  = 1'b0;
    mxu_done = 1'b0;
    m_ready  = 1'b0;
    chk("job1 a[7:0]",     128'(mxu_data_a[7:0]),     128'h01);
    chk("job1 a[127:120]", 128'(mxu_data_a[127:120]), 128'h10);
    chk("job1 b[7:0]",     128'(mxu_data_b[7:0]),     128'h11);
    chk("job1 A",          mxu_data_a, pack_inc(8'h01));
    chk("job1 B",          mxu_data_b, pack_inc(8'h11));
    chk("job1 cycles",     128'(mxu_cycles), 128'd1);

    // Job 2: gapped input, spurious done while loading A, toggling m_ready.
    load(pack_inc(8'h40), pack_inc(8'h80), 1'b0, 3, 1'b1);
    run_wait(2, 32'hA000_0000, 32'd1);
    drain(32'hA000_0000, 32'd1, 1'b1);

    // Aborted job: reset during WAIT, done held high across and after reset.
    load(pack_inc(8'h21), pack_inc(8'h31), 1'b1, 1, 1'b0);
    tick();
    tick();
    reset    = 1'b0;
    mxu_done = 1'b1;
    #1;
    chk_reset_vals("abort");
    tick();
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("abort m_valid", 128'(m_valid), 128'd0);
      chk("abort busy",    128'(busy),    128'd0);
      chk("abort s_ready", 128'(s_ready), 128'd1);
    end
    mxu_done = 1'b0;

    // Fresh job after abort, then a back-to-back job replacing every operand.
    load(pack_inc(8'h21), pack_inc(8'h31), 1'b1, 1, 1'b0);
    run_wait(1, 32'h1234_0000, 32'h10);
    drain(32'h1234_0000, 32'h10, 1'b0);
    load({16{8'hFF}}, pack_inc(8'h60), 1'b0, 1, 1'b0);
    run_wait(0, 32'hC0DE_0000, 32'h11);
    drain(32'hC0DE_0000, 32'h11, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mxu_host_if.md
# mxu_host_if

Host-side front end for the matrix multiply unit. It accepts operand bytes over a valid/ready byte stream and assembles the A and B matrices into the flat operand buses the unit consumes. It then pulses the unit's start, waits for done, captures the accumulator results and streams them back out as 32-bit words over a valid/ready stream. Together with the unit it forms the complete load → compute → read-back path.

## Interface
- SIZE, 4, matrix dimension (SIZE×SIZE operands, SIZE*SIZE results)
- N = SIZE*SIZE is a derived constant, not a parameter.
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion is synchronous to clk upstream
- s_valid  in  1  operand byte valid
- s_ready  out  1  operand byte accepted when s_valid & s_ready at clk edge
- s_data  in  8  operand byte: N bytes of A row-major, then N bytes of B row-major
- cycles_cfg  in  1  value forwarded to the unit's cycles input
- mxu_data_a  out  N*8  A packed: element (r,c) at bits [(r*SIZE+c)*8 +: 8]
- mxu_data_b  out  N*8  B packed identically, row-major, untransposed
- mxu_start  out  1  one-cycle start pulse to the unit
- mxu_cycles  out  1  latched cycles_cfg
- mxu_done  in  1  completion flag from the unit
- mxu_d_in  in  N×32  unit accumulator outputs, element k = r*SIZE+c
- m_valid  out  1  result word valid
- m_ready  in  1  result word accepted when m_valid & m_ready
- m_data  out  32  result word
- m_last  out  1  high with the final result word (k = N-1)
- busy  out  1  high in START, WAIT and DRAIN

## Operation
- FSM states: LOAD_A, LOAD_B, START, WAIT, DRAIN. Reset state: LOAD_A.
- LOAD_A: s_ready=1. Each accepted byte is written to A[idx] and idx increments. When the byte at idx=N-1 is accepted, idx clears and the FSM moves to LOAD_B.
- LOAD_B: same behaviour into B. On acceptance of byte N-1:
  - cycles_cfg is latched into mxu_cycles.
  - idx clears.
  - FSM moves to START.
- START: mxu_start=1 for exactly this cycle, then the FSM moves to WAIT.
- WAIT: mxu_done is sampled each cycle. In the first cycle it is 1, all N words of mxu_d_in are captured into the result registers and the FSM moves to DRAIN.
- DRAIN: m_valid=1, m_data=result[idx], m_last=(idx==N-1). On each m_valid & m_ready:
  - idx increments.
  - On the last word, idx clears and the FSM returns to LOAD_A.
- s_ready=0 outside LOAD_A/LOAD_B. s_valid in those states is ignored and no data is consumed.
- mxu_done is ignored in every state except WAIT, including the START cycle itself.
- mxu_data_a/b, mxu_cycles and result registers are registered:
  - Operand and cycles values are held stable from the last B byte through the end of WAIT and beyond.
  - Results are held until overwritten by the next capture.
- idx width: $clog2(N); it is never compared against N, only against N-1.

## Timing
- Reset values (async, immediate):
  - state=LOAD_A, idx=0
  - s_ready=1, m_valid=0, m_last=0, m_data=0
  - mxu_start=0, mxu_cycles=0, busy=0
  - mxu_data_a/b all zeros, result registers all zeros
- Throughput: 1 operand byte per cycle, so loading with s_valid continuously high takes 2N cycles.
- Last B byte accepted at edge t:
  - mxu_start=1 during cycle t+1.
  - WAIT begins at t+2.
- mxu_done high in cycle w of WAIT: DRAIN begins at w+1 and the first word is presented at w+1.
- With m_ready continuously high, N words stream in N consecutive cycles and LOAD_A is re-entered the cycle after the last handshake.
- Backpressure: while m_valid=1 and m_ready=0, m_data and m_last hold unchanged. m_valid never deasserts before its handshake.
- Reset asserted in any state, including mid-load, WAIT or DRAIN:
  - All of the above return to reset values.
  - A partially received matrix is discarded.
  - A pending start or drain is abandoned.
- The unit's done-driven internal reset requires no action from this block; done is consumed once per capture.

## Test plan
- Load A=0x01..0x10, B=0x11..0x20 with s_valid held high and cycles_cfg=1 → mxu_data_a[7:0]=0x01, mxu_data_a[127:120]=0x10, mxu_data_b[7:0]=0x11; mxu_start pulses exactly 1 cycle, 1 cycle after the 32nd byte; mxu_cycles=1.
- Responder model raises mxu_done 5 cycles into WAIT with mxu_d_in[k]=k*0x100 → m_data sequence 0x000, 0x100, …, 0xF00 on 16 consecutive cycles, m_last only on 0xF00, then s_ready=1.
- Toggle m_ready 1010… during DRAIN → each word is held until accepted, with no word lost or repeated; 16 handshakes total.
- s_valid with gaps (every 3rd cycle) → bytes land at the correct indices; a spurious mxu_done=1 during LOAD_A is ignored (no state change).
- Assert reset for 1 cycle while in WAIT, then reload and re-run → no DRAIN from the aborted job; outputs at reset values; the second job completes correctly with a fresh capture.
- Back-to-back jobs: second job's A=all 0xFF → second capture overwrites results and the first job's operands are fully replaced.
